// File: rtl/video_timing_multimode.sv
// rtl/video_timing_multimode.sv - multi-mode raster timing generator with frame-boundary mode switching
// Optional colour-bar pattern output rgb_o when VTM_TPG_EN is defined.
module video_timing_multimode #(
  parameter int NMODES = 2,
  parameter int CW = 12,
  parameter int FCW = 8,
  parameter logic [NMODES*CW-1:0] H_ACTIVE = {12'd1920, 12'd1280},
  parameter logic [NMODES*CW-1:0] H_FP     = {12'd88,   12'd110},
  parameter logic [NMODES*CW-1:0] H_SYNC   = {12'd44,   12'd40},
  parameter logic [NMODES*CW-1:0] H_BP     = {12'd148,  12'd220},
  parameter logic [NMODES*CW-1:0] V_ACTIVE = {12'd1080, 12'd720},
  parameter logic [NMODES*CW-1:0] V_FP     = {12'd4,    12'd5},
  parameter logic [NMODES*CW-1:0] V_SYNC   = {12'd5,    12'd5},
  parameter logic [NMODES*CW-1:0] V_BP     = {12'd36,   12'd20},
  parameter logic [NMODES-1:0]    SYNC_POL = {1'b1, 1'b1},
  parameter int RST_MODE = 0,
  localparam int MW = (NMODES > 1) ? $clog2(NMODES) : 1
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           en_i,
  input  logic [MW-1:0]  mode_i,
  input  logic           mode_req_i,
  output logic [MW-1:0]  mode_o,
  output logic           mode_ack_o,
  output logic           mode_err_o,
  output logic           hs_o,
  output logic           vs_o,
  output logic           de_o,
  output logic [CW-1:0]  hcount_o,
  output logic [CW-1:0]  vcount_o,
  output logic           sof_o,
  output logic [FCW-1:0] frame_cnt_o
`ifdef VTM_TPG_EN
  ,
  output logic [23:0]    rgb_o
`endif
);

  typedef enum logic {IDLE, PENDING} req_state_t;

  req_state_t state_q, state_d;
  logic [MW-1:0] mode_q, mode_d, pend_q, pend_d, target;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          sw_q, sw_d, wrap_q;

  logic [CW-1:0] ha, va, ht, vt, hs_beg, hs_end, vs_beg, vs_end;
  logic          pol, req_ok, req_bad, frame_end, apply;
  logic          sof_now, de_now, hs_win, vs_win;

  function automatic logic [CW-1:0] fld(input logic [NMODES*CW-1:0] tbl, input logic [MW-1:0] m);
    return tbl[int'(m)*CW +: CW];
  endfunction

  always_comb begin
    ha     = fld(H_ACTIVE, mode_q);
    va     = fld(V_ACTIVE, mode_q);
    hs_beg = ha + fld(H_FP, mode_q);
    hs_end = hs_beg + fld(H_SYNC, mode_q);
    ht     = hs_end + fld(H_BP, mode_q);
    vs_beg = va + fld(V_FP, mode_q);
    vs_end = vs_beg + fld(V_SYNC, mode_q);
    vt     = vs_end + fld(V_BP, mode_q);
    pol    = SYNC_POL[mode_q];
  end

  assign req_ok    = mode_req_i && (int'(mode_i) < NMODES);
  assign req_bad   = mode_req_i && !(int'(mode_i) < NMODES);
  assign frame_end = en_i && (h_q == ht - 1'b1) && (v_q == vt - 1'b1);
  assign sof_now   = en_i && (h_q == '0) && (v_q == '0);
  assign de_now    = en_i && (h_q < ha) && (v_q < va);
  assign hs_win    = en_i && (h_q >= hs_beg) && (h_q < hs_end);
  assign vs_win    = en_i && (v_q >= vs_beg) && (v_q < vs_end);

  // A request arriving on the frame-end cycle itself is applied at that boundary.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    h_d     = h_q;
    v_d     = v_q;
    sw_d    = 1'b0;
    target  = req_ok ? mode_i : pend_q;
    apply   = ((state_q == PENDING) && (!en_i || frame_end)) || (req_ok && frame_end);
    if (apply) begin
      mode_d  = target;
      h_d     = '0;
      v_d     = '0;
      sw_d    = 1'b1;
      state_d = IDLE;
    end else begin
      if (req_ok) begin
        state_d = PENDING;
        pend_d  = mode_i;
      end
      if (en_i) begin
        if (h_q == ht - 1'b1) begin
          h_d = '0;
          v_d = (v_q == vt - 1'b1) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mode_q  <= MW'(RST_MODE);
      h_q     <= '0;
      v_q     <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      h_q     <= h_d;
      v_q     <= v_d;
      sw_q    <= sw_d;
    end
  end

  // wrap_q carries a completed frame forward so the count steps together with sof_o.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hcount_o    <= '0;
      vcount_o    <= '0;
      de_o        <= 1'b0;
      hs_o        <= ~SYNC_POL[RST_MODE];
      vs_o        <= ~SYNC_POL[RST_MODE];
      sof_o       <= 1'b0;
      mode_o      <= MW'(RST_MODE);
      mode_ack_o  <= 1'b0;
      mode_err_o  <= 1'b0;
      frame_cnt_o <= '0;
      wrap_q      <= 1'b0;
    end else begin
      hcount_o   <= h_q;
      vcount_o   <= v_q;
      de_o       <= de_now;
      hs_o       <= hs_win ? pol : ~pol;
      vs_o       <= vs_win ? pol : ~pol;
      sof_o      <= sof_now;
      mode_o     <= mode_q;
      mode_ack_o <= sw_q;
      mode_err_o <= req_bad;
      if (frame_end) begin
        wrap_q <= 1'b1;
      end else if (sof_now) begin
        wrap_q <= 1'b0;
      end
      if (sof_now && wrap_q) begin
        frame_cnt_o <= frame_cnt_o + 1'b1;
      end
    end
  end

`ifdef VTM_TPG_EN
  logic [CW-1:0] bar_w, bar_px_q, bar_px_d;
  logic [3:0]    bar_idx_q, bar_idx_d;

  function automatic logic [23:0] bar_rgb(input logic [3:0] idx);
    case (idx)
      4'd0:    return 24'hFFFFFF;
      4'd1:    return 24'hFFFF00;
      4'd2:    return 24'h00FFFF;
      4'd3:    return 24'h00FF00;
      4'd4:    return 24'hFF00FF;
      4'd5:    return 24'hFF0000;
      4'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Bar position tracks h incrementally; index 8 marks the black remainder.
  always_comb begin
    bar_w     = ha >> 3;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (h_d == '0) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (h_d != h_q) begin
      if (bar_px_q == bar_w - 1'b1) begin
        bar_px_d = '0;
        if (bar_idx_q != 4'd8) begin
          bar_idx_d = bar_idx_q + 1'b1;
        end
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      rgb_o     <= '0;
    end else begin
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      rgb_o     <= (de_now && (bar_w != '0)) ? bar_rgb(bar_idx_q) : 24'h000000;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_multimode.sv
// tb/tb_video_timing_multimode.sv - scoreboard bench for video_timing_multimode against a reference raster model
module tb_video_timing_multimode;
  localparam int NM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       mode_req = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic [1:0] mode_o;
  logic       mode_ack_o, mode_err_o, hs_o, vs_o, de_o, sof_o;
  logic [7:0] hcount_o, vcount_o;
  logic [3:0] frame_cnt_o;

  video_timing_multimode #(
    .NMODES(NM), .CW(8), .FCW(4),
    .H_ACTIVE({8'd4, 8'd16, 8'd8}),
    .H_FP    ({8'd1, 8'd1,  8'd2}),
    .H_SYNC  ({8'd1, 8'd3,  8'd2}),
    .H_BP    ({8'd1, 8'd2,  8'd2}),
    .V_ACTIVE({8'd2, 8'd6,  8'd4}),
    .V_FP    ({8'd1, 8'd1,  8'd1}),
    .V_SYNC  ({8'd1, 8'd2,  8'd1}),
    .V_BP    ({8'd1, 8'd1,  8'd1}),
    .SYNC_POL(3'b101),
    .RST_MODE(0)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .mode_i(mode_i), .mode_req_i(mode_req),
    .mode_o(mode_o), .mode_ack_o(mode_ack_o), .mode_err_o(mode_err_o),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .hcount_o(hcount_o), .vcount_o(vcount_o),
    .sof_o(sof_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  int HA[NM] = '{8, 16, 4};
  int HF[NM] = '{2, 1, 1};
  int HS[NM] = '{2, 3, 1};
  int HB[NM] = '{2, 2, 1};
  int VA[NM] = '{4, 6, 2};
  int VF[NM] = '{1, 1, 1};
  int VS[NM] = '{1, 2, 1};
  int VB[NM] = '{1, 1, 1};
  bit POL[NM] = '{1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic       hs, vs, de, sof, ack, err;
    logic [1:0] mode;
    logic [7:0] hc, vc;
    logic [3:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0, errors = 0, ack_cnt = 0, err_cnt = 0;

  // Reference raster: position, active mode, pending request, frames completed.
  int mh = 0, mv = 0, mm = 0, mtarget = 0, mfc = 0;
  bit mpend = 0, mack = 0, mwrap = 0;

  always @(posedge clk) begin : model
    obs_t e;
    int ht, vt;
    bit valid, fend;
    if (!rst_n) begin
      mh = 0; mv = 0; mm = 0; mpend = 0; mack = 0; mwrap = 0; mfc = 0;
      e = '0;
      e.hs = !POL[0];
      e.vs = !POL[0];
    end else begin
      ht = HA[mm] + HF[mm] + HS[mm] + HB[mm];
      vt = VA[mm] + VF[mm] + VS[mm] + VB[mm];
      e.hc  = mh[7:0];
      e.vc  = mv[7:0];
      e.de  = en && mh < HA[mm] && mv < VA[mm];
      e.hs  = (en && mh >= HA[mm] + HF[mm] && mh < HA[mm] + HF[mm] + HS[mm]) ? POL[mm] : !POL[mm];
      e.vs  = (en && mv >= VA[mm] + VF[mm] && mv < VA[mm] + VF[mm] + VS[mm]) ? POL[mm] : !POL[mm];
      e.sof = en && mh == 0 && mv == 0;
      if (e.sof && mwrap) begin
        mfc++;
        mwrap = 0;
      end
      e.fc   = mfc[3:0];
      e.mode = mm[1:0];
      e.ack  = mack;
      e.err  = mode_req && (int'(mode_i) >= NM);
      valid  = mode_req && (int'(mode_i) < NM);
      fend   = en && mh == ht - 1 && mv == vt - 1;
      mack   = 0;
      if (fend) mwrap = 1;
      if ((mpend && !en) || (fend && (mpend || valid))) begin
        mm = valid ? int'(mode_i) : mtarget;
        mh = 0; mv = 0; mpend = 0; mack = 1;
      end else begin
        if (valid) begin
          mpend = 1;
          mtarget = int'(mode_i);
        end
        if (en) begin
          if (mh == ht - 1) begin
            mh = 0;
            mv = (mv == vt - 1) ? 0 : mv + 1;
          end else begin
            mh++;
          end
        end
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {hs_o, vs_o, de_o, sof_o, mode_ack_o, mode_err_o, mode_o, hcount_o, vcount_o, frame_cnt_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b sof=%b ack=%b err=%b mode=%0d fc=%0d required h=%0d v=%0d hs=%b vs=%b de=%b sof=%b ack=%b err=%b mode=%0d fc=%0d",
                 $time, a.hc, a.vc, a.hs, a.vs, a.de, a.sof, a.ack, a.err, a.mode, a.fc,
                 e.hc, e.vc, e.hs, e.vs, e.de, e.sof, e.ack, e.err, e.mode, e.fc);
      end
      if (a.ack === 1'b1) ack_cnt++;
      if (a.err === 1'b1) err_cnt++;
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
      mode_req = 1'b0;
    end
  endtask

  task automatic req(int m);
    cyc();
    mode_req = 1'b1;
    mode_i = m[1:0];
  endtask

  task automatic wait_pos(int hh, int vv);
    int k = 0;
    while (!(mh == hh && mv == vv) && k < 2000) begin
      cyc();
      k++;
    end
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_pos got h=%0d v=%0d required h=%0d v=%0d", mh, mv, hh, vv);
    end
  endtask

  task automatic check(string name, int act, int req_val);
    checks++;
    if (act != req_val) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req_val);
    end
  endtask

  initial begin
    int a0, e0;
    cyc(3);
    check("reset_hs", int'(hs_o), 0);
    check("reset_vs", int'(vs_o), 0);
    check("reset_de", int'(de_o), 0);
    check("reset_mode", int'(mode_o), 0);
    rst_n = 1'b1;
    cyc();
    check("first_sof", int'(sof_o), 1);
    check("first_hcount", int'(hcount_o), 0);
    check("first_de", int'(de_o), 1);
    cyc(294);
    check("three_frames_cnt", int'(frame_cnt_o), 3);
    check("three_frames_sof", int'(sof_o), 1);

    a0 = ack_cnt;
    wait_pos(5, 1);
    req(1);
    cyc(3);
    req(0);
    cyc();
    wait_pos(0, 0);
    cyc(3);
    check("last_wins_ack", ack_cnt - a0, 1);
    check("last_wins_mode", int'(mode_o), 0);

    a0 = ack_cnt;
    wait_pos(4, 2);
    req(1);
    cyc();
    wait_pos(0, 0);
    cyc(3);
    check("switch_ack", ack_cnt - a0, 1);
    check("switch_mode", int'(mode_o), 1);
    cyc(440);

    e0 = err_cnt;
    req(3);
    cyc(3);
    check("err_idle", err_cnt - e0, 1);
    check("err_idle_mode", int'(mode_o), 1);

    a0 = ack_cnt;
    e0 = err_cnt;
    wait_pos(3, 3);
    req(0);
    cyc(2);
    req(3);
    cyc();
    wait_pos(0, 0);
    cyc(3);
    check("err_pending", err_cnt - e0, 1);
    check("err_pending_ack", ack_cnt - a0, 1);
    check("err_pending_mode", int'(mode_o), 0);

    wait_pos(3, 1);
    en = 1'b0;
    cyc(5);
    check("freeze_hcount", int'(hcount_o), 3);
    check("freeze_de", int'(de_o), 0);
    check("freeze_hs", int'(hs_o), 0);
    en = 1'b1;
    cyc();
    check("resume_hcount", int'(hcount_o), 3);
    check("resume_de", int'(de_o), 1);
    cyc(2);
    check("resume_step", int'(hcount_o), 5);

    a0 = ack_cnt;
    wait_pos(2, 2);
    req(1);
    cyc();
    en = 1'b0;
    cyc();
    en = 1'b1;
    cyc(3);
    check("freeze_switch_ack", ack_cnt - a0, 1);
    check("freeze_switch_mode", int'(mode_o), 1);

    wait_pos(5, 2);
    req(0);
    cyc();
    rst_n = 1'b0;
    cyc(2);
    check("midreset_mode", int'(mode_o), 0);
    check("midreset_hcount", int'(hcount_o), 0);
    rst_n = 1'b1;
    a0 = ack_cnt;
    cyc(250);
    check("midreset_no_ack", ack_cnt - a0, 0);
    check("midreset_mode_kept", int'(mode_o), 0);

    repeat (1500) begin
      cyc();
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        mode_req = 1'b1;
        mode_i = 2'($urandom_range(0, 3));
      end
    end
    en = 1'b1;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
